// File: rtl/sm4_dec_core.sv
// Iterative SM4 block decryptor: expands the master key into a 32-entry round-key file,
// then runs the 32 rounds in reverse key order, RPC rounds per clock.
module sm4_dec_core #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         key_loaded,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  localparam int N = 32 / RPC;

  if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
    $error("sm4_dec_core: RPC must be 1, 2 or 4");
  end

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_KEYED, S_DEC, S_OUT} state_e;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] l_data(input logic [31:0] b);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  // CK byte j of round i is (4i+j)*7 mod 256, derived arithmetically from the round index
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [7:0] base;
    logic [31:0] w;
    base = {1'b0, i, 2'b00};
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = (base + 8'(j)) * 8'd7;
    end
    return w;
  endfunction

  state_e        state_q;
  logic [4:0]    cnt_q;
  logic          key_ready_q, key_loaded_q, out_valid_q, busy_q;
  logic [127:0]  pt_q;
  logic [127:0]  st_q, st_d;
  logic [31:0]   rk_q [0:31];
  logic [31:0]   rk_new [0:RPC-1];
  logic [4:0]    rk_idx [0:RPC-1];
  logic          load_key, load_ct, last_rnd, in_ready_c;

  assign in_ready_c = (state_q == S_KEYED) && !key_valid;
  assign load_key   = key_valid && key_ready_q;
  assign load_ct    = in_valid && in_ready_c;
  assign last_rnd   = (cnt_q == 5'(N - 1));

  // Shared round chain: key expansion and decryption never overlap, so one set of sbox lanes serves both
  always_comb begin
    logic [31:0] w0, w1, w2, w3, tin, f, nw;
    logic [4:0]  ri;
    w0 = st_q[127:96];
    w1 = st_q[95:64];
    w2 = st_q[63:32];
    w3 = st_q[31:0];
    for (int r = 0; r < RPC; r++) begin
      ri  = cnt_q * 5'(RPC) + 5'(r);
      tin = w1 ^ w2 ^ w3 ^ ((state_q == S_KEYEXP) ? ck_word(ri) : rk_q[5'd31 - ri]);
      f   = tau(tin);
      nw  = w0 ^ ((state_q == S_KEYEXP) ? l_key(f) : l_data(f));
      rk_idx[r] = ri;
      rk_new[r] = nw;
      w0 = w1;
      w1 = w2;
      w2 = w3;
      w3 = nw;
    end
    st_d = {w0, w1, w2, w3};
  end

  always_ff @(posedge clk) begin
    if (load_key) begin
      st_q <= key ^ FK;
    end else if (load_ct) begin
      st_q <= ct;
    end else if (state_q == S_KEYEXP || state_q == S_DEC) begin
      st_q <= st_d;
    end
    if (state_q == S_KEYEXP) begin
      for (int r = 0; r < RPC; r++) begin
        rk_q[rk_idx[r]] <= rk_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_ready_q  <= 1'b1;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      pt_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_KEYED: begin
          if (key_valid) begin
            state_q      <= S_KEYEXP;
            cnt_q        <= '0;
            key_ready_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            busy_q       <= 1'b1;
          end else if (state_q == S_KEYED && in_valid) begin
            state_q     <= S_DEC;
            cnt_q       <= '0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_KEYEXP: begin
          if (last_rnd) begin
            state_q      <= S_KEYED;
            cnt_q        <= '0;
            key_ready_q  <= 1'b1;
            key_loaded_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DEC: begin
          if (last_rnd) begin
            state_q     <= S_OUT;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            pt_q        <= {st_d[31:0], st_d[63:32], st_d[95:64], st_d[127:96]};
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_KEYED;
            out_valid_q <= 1'b0;
            key_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_ready  = key_ready_q;
  assign key_loaded = key_loaded_q;
  assign in_ready   = in_ready_c;
  assign out_valid  = out_valid_q;
  assign pt         = pt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sm4_dec_core.sv
// Bench for sm4_dec_core: table-driven known-answer and model-derived vectors plus
// hand-written sequences for backpressure, re-key priority, mid-round reset and RPC variants.
module tb_sm4_dec_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid, key_ready, key_loaded;
  logic [127:0] key;
  logic         in_valid, in_ready;
  logic [127:0] ct;
  logic         out_valid, out_ready;
  logic [127:0] pt;
  logic         busy;

  logic [1:0]   a_kv, a_kr, a_kl, a_iv, a_ir, a_ov, a_or, a_busy;
  logic [127:0] a_key, a_ct;
  logic [127:0] a_pt [2];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sm4_dec_core #(.RPC(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .key_loaded(key_loaded), .in_valid(in_valid), .in_ready(in_ready), .ct(ct),
    .out_valid(out_valid), .out_ready(out_ready), .pt(pt), .busy(busy)
  );

  sm4_dec_core #(.RPC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_valid(a_kv[0]), .key_ready(a_kr[0]), .key(a_key),
    .key_loaded(a_kl[0]), .in_valid(a_iv[0]), .in_ready(a_ir[0]), .ct(a_ct),
    .out_valid(a_ov[0]), .out_ready(a_or[0]), .pt(a_pt[0]), .busy(a_busy[0])
  );

  sm4_dec_core #(.RPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_valid(a_kv[1]), .key_ready(a_kr[1]), .key(a_key),
    .key_loaded(a_kl[1]), .in_valid(a_iv[1]), .in_ready(a_ir[1]), .ct(a_ct),
    .out_valid(a_ov[1]), .out_ready(a_or[1]), .pt(a_pt[1]), .busy(a_busy[1])
  );

  // Reference SM4 encryptor with the standard CK table
  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  localparam logic [31:0] CKT [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  logic [31:0] m_rk [32];

  function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_tau(input logic [31:0] a);
    return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
  endfunction

  task automatic m_expand(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] b;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      b = m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ CKT[i]);
      k[i+4] = k[i] ^ b ^ m_rol(b, 13) ^ m_rol(b, 23);
      m_rk[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] m_enc(input logic [127:0] p);
    logic [31:0] x [36];
    logic [31:0] b;
    x[0] = p[127:96]; x[1] = p[95:64]; x[2] = p[63:32]; x[3] = p[31:0];
    for (int i = 0; i < 32; i++) begin
      b = m_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ m_rk[i]);
      x[i+4] = x[i] ^ b ^ m_rol(b, 2) ^ m_rol(b, 10) ^ m_rol(b, 18) ^ m_rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input bit with_ct, output int lat);
    chk("key_ready_before_key", key_ready, 1);
    key = k;
    key_valid = 1'b1;
    if (with_ct) begin
      in_valid = 1'b1;
      #1;
      chk("in_ready_low_when_key_wins", in_ready, 0);
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    in_valid  = 1'b0;
    chk("busy_in_keyexp", busy, 1);
    chk("key_loaded_drops", key_loaded, 0);
    lat = 0;
    while (!key_loaded && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic decrypt(input logic [127:0] c, output int lat);
    chk("in_ready_before_ct", in_ready, 1);
    ct = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", out_valid, 0);
    chk("in_ready_after_take", in_ready, 1);
  endtask

  task automatic run_alt(input int d, input int n, input logic [127:0] k,
                         input logic [127:0] c, input logic [127:0] p);
    int lat;
    chk("alt_key_ready", a_kr[d], 1);
    a_key = k;
    a_kv[d] = 1'b1;
    @(posedge clk); #1;
    a_kv[d] = 1'b0;
    chk("alt_busy", a_busy[d], 1);
    lat = 0;
    while (!a_kl[d] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("alt_key_latency", lat, n);
    a_ct = c;
    a_iv[d] = 1'b1;
    chk("alt_in_ready", a_ir[d], 1);
    @(posedge clk); #1;
    a_iv[d] = 1'b0;
    lat = 0;
    while (!a_ov[d] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("alt_dec_latency", lat, n);
    chk("alt_pt", a_pt[d], p);
    a_or[d] = 1'b1;
    @(posedge clk); #1;
    a_or[d] = 1'b0;
    chk("alt_in_ready_after_take", a_ir[d], 1);
  endtask

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] STD_CT  = 128'h681EDF34D206965E86B3E94F536E4246;

  initial begin
    vec_t tv [4];
    int lat;
    logic [127:0] hold_pt, zp;
    bit bad;

    rst_n = 1'b0;
    key_valid = 1'b0; key = '0; in_valid = 1'b0; ct = '0; out_ready = 1'b0;
    a_kv = '0; a_iv = '0; a_or = '0; a_key = '0; a_ct = '0;

    m_expand(STD_KEY);
    tv[0] = '{ct: STD_CT, pt: STD_KEY};
    tv[1] = '{ct: m_enc(128'h0), pt: 128'h0};
    tv[2] = '{ct: m_enc({4{32'hFFFFFFFF}}), pt: {4{32'hFFFFFFFF}}};
    tv[3] = '{ct: m_enc(128'h00112233445566778899AABBCCDDEEFF),
              pt: 128'h00112233445566778899AABBCCDDEEFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pt", pt, 0);
    rst_n = 1'b1;

    // Ciphertext offered before any key must be ignored
    ct = STD_CT;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("nokey_in_ready", in_ready, 0);
    chk("nokey_busy", busy, 0);
    chk("nokey_key_ready", key_ready, 1);
    in_valid = 1'b0;

    load_key(STD_KEY, 1'b0, lat);
    chk("key_latency", lat, 32);
    chk("rk0", dut.rk_q[0], 32'hF12186F9);
    chk("rk31", dut.rk_q[31], 32'h9124A012);
    chk("keyed_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      decrypt(tv[i].ct, lat);
      chk("dec_latency", lat, 32);
      chk("dec_pt", pt, tv[i].pt);
      take_out();
    end

    // Output held under backpressure; key and ct offers are held off meanwhile
    decrypt(STD_CT, lat);
    chk("bp_latency", lat, 32);
    hold_pt = pt;
    key_valid = 1'b1;
    in_valid = 1'b1;
    key = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin
        key_valid = 1'b0;
        in_valid = 1'b0;
      end
      chk("bp_out_valid", out_valid, 1);
      chk("bp_pt_stable", pt, hold_pt);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_key_ready", key_ready, 0);
    end
    chk("bp_pt_value", pt, STD_KEY);
    take_out();

    // key and ct offered together: key wins, then zero-key decryption
    load_key(128'h0, 1'b1, lat);
    chk("rekey_latency", lat, 32);
    chk("rekey_no_output", out_valid, 0);
    m_expand(128'h0);
    zp = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
    decrypt(m_enc(zp), lat);
    chk("zero_key_latency", lat, 32);
    chk("zero_key_pt", pt, zp);
    take_out();

    // Reset pulsed during round 17 of a decryption
    ct = STD_CT;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("mid_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_ready", key_ready, 1);
    chk("mid_rst_key_loaded", key_loaded, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pt", pt, 0);
    #3;
    rst_n = 1'b1;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || in_ready || key_loaded) bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("post_reset_quiet", bad, 0);

    m_expand(STD_KEY);
    load_key(STD_KEY, 1'b0, lat);
    chk("reload_latency", lat, 32);
    decrypt(STD_CT, lat);
    chk("reload_pt", pt, STD_KEY);
    take_out();

    run_alt(0, 16, STD_KEY, STD_CT, STD_KEY);
    run_alt(1, 8, STD_KEY, STD_CT, STD_KEY);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
